// File: rtl/head_table_if.sv
// Command, write-back and clear signals of the hash-table head-pointer store.
// Signal suffixes (_i/_o) are named from the head_table (slave) side.
interface head_table_if #(
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 16,
  parameter int BUCKET_WIDTH   = 8,
  parameter int HEAD_PTR_WIDTH = 10
);
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [1:0]                in_cmd_i;
  logic [KEY_WIDTH-1:0]      in_key_i;
  logic [VALUE_WIDTH-1:0]    in_value_i;
  logic [BUCKET_WIDTH-1:0]   in_bucket_i;

  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [1:0]                out_cmd_o;
  logic [KEY_WIDTH-1:0]      out_key_o;
  logic [VALUE_WIDTH-1:0]    out_value_o;
  logic [BUCKET_WIDTH-1:0]   out_bucket_o;
  logic [HEAD_PTR_WIDTH-1:0] out_head_ptr_o;
  logic                      out_head_ptr_val_o;

  logic                      wr_en_i;
  logic [BUCKET_WIDTH-1:0]   wr_bucket_i;
  logic [HEAD_PTR_WIDTH-1:0] wr_head_ptr_i;
  logic                      wr_head_ptr_val_i;

  logic                      clear_ram_run_i;
  logic                      clear_ram_done_o;

  modport master (
    output in_valid_i, in_cmd_i, in_key_i, in_value_i, in_bucket_i,
    output out_ready_i,
    output wr_en_i, wr_bucket_i, wr_head_ptr_i, wr_head_ptr_val_i,
    output clear_ram_run_i,
    input  in_ready_o,
    input  out_valid_o, out_cmd_o, out_key_o, out_value_o, out_bucket_o,
    input  out_head_ptr_o, out_head_ptr_val_o,
    input  clear_ram_done_o
  );

  modport slave (
    input  in_valid_i, in_cmd_i, in_key_i, in_value_i, in_bucket_i,
    input  out_ready_i,
    input  wr_en_i, wr_bucket_i, wr_head_ptr_i, wr_head_ptr_val_i,
    input  clear_ram_run_i,
    output in_ready_o,
    output out_valid_o, out_cmd_o, out_key_o, out_value_o, out_bucket_o,
    output out_head_ptr_o, out_head_ptr_val_o,
    output clear_ram_done_o
  );
endinterface

// File: rtl/head_table.sv
// Bucket-indexed head-pointer store: annotates each command with its bucket's chain head,
// takes head updates back from data_table, and can sweep the whole table to zero.
module head_table #(
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 16,
  parameter int BUCKET_WIDTH   = 8,
  parameter int HEAD_PTR_WIDTH = 10
) (
  input logic        clk_i,
  input logic        rst_i,
  head_table_if.slave bus
);

  localparam int DEPTH   = 2 ** BUCKET_WIDTH;
  localparam int ENTRY_W = HEAD_PTR_WIDTH + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [BUCKET_WIDTH-1:0] ONE_ADDR  = {{(BUCKET_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BUCKET_WIDTH-1:0] LAST_ADDR = {BUCKET_WIDTH{1'b1}};
  localparam logic [BUCKET_WIDTH-1:0] PRE_LAST  = LAST_ADDR - ONE_ADDR;
  localparam logic [ENTRY_W-1:0]      ZERO_ENTRY = {ENTRY_W{1'b0}};

  // Entry layout: {head_ptr, head_ptr_val}
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] ram_q;

  logic [0:0]              state_q,     state_d;
  logic [BUCKET_WIDTH-1:0] clr_addr_q,  clr_addr_d;
  logic                    done_q,      done_d;

  logic                    out_valid_q, out_valid_d;
  logic [1:0]              out_cmd_q,   out_cmd_d;
  logic [KEY_WIDTH-1:0]    out_key_q,   out_key_d;
  logic [VALUE_WIDTH-1:0]  out_value_q, out_value_d;
  logic [BUCKET_WIDTH-1:0] out_bucket_q, out_bucket_d;
  logic [ENTRY_W-1:0]      head_q,      head_d;
  logic                    head_sel_ram_q, head_sel_ram_d;

  logic                    clearing_s;
  logic                    in_ready_s;
  logic                    accept_s;
  logic                    stall_s;
  logic                    wr_live_s;
  logic [ENTRY_W-1:0]      wr_entry_s;
  logic                    ram_we_s;
  logic [BUCKET_WIDTH-1:0] ram_waddr_s;
  logic [ENTRY_W-1:0]      ram_wdata_s;
  logic [ENTRY_W-1:0]      head_out_s;

  // Handshake qualifiers and RAM write-port steering (clear sweep overrides write-back)
  always_comb begin
    clearing_s = (state_q == ST_CLEAR);
    in_ready_s = !clearing_s && (!out_valid_q || bus.out_ready_i);
    accept_s   = bus.in_valid_i && in_ready_s;
    stall_s    = out_valid_q && !bus.out_ready_i;
    wr_live_s  = bus.wr_en_i && !clearing_s;
    wr_entry_s = {bus.wr_head_ptr_i, bus.wr_head_ptr_val_i};
    if (clearing_s) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = clr_addr_q;
      ram_wdata_s = ZERO_ENTRY;
    end else begin
      ram_we_s    = wr_live_s;
      ram_waddr_s = bus.wr_bucket_i;
      ram_wdata_s = wr_entry_s;
    end
  end

  // Storage array: one write port, one registered read port loaded only on accept
  always_ff @(posedge clk_i) begin
    if (ram_we_s) begin
      mem[ram_waddr_s] <= ram_wdata_s;
    end
    if (accept_s) begin
      ram_q <= mem[bus.in_bucket_i];
    end
  end

  // Clear sequencer; done is pre-computed so it is high during the last-address cycle
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear_ram_run_i) begin
          state_d    = ST_CLEAR;
          clr_addr_d = {BUCKET_WIDTH{1'b0}};
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (bus.clear_ram_run_i) begin
          clr_addr_d = {BUCKET_WIDTH{1'b0}};
        end else if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_addr_d = clr_addr_q + ONE_ADDR;
        end else begin
          clr_addr_d = clr_addr_q + ONE_ADDR;
          done_d     = (clr_addr_q == PRE_LAST);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        clr_addr_d = {BUCKET_WIDTH{1'b0}};
      end
    endcase
  end

  // Output stage: capture on accept, hold on stall; same-bucket writes bypass the RAM read
  always_comb begin
    out_valid_d    = out_valid_q;
    out_cmd_d      = out_cmd_q;
    out_key_d      = out_key_q;
    out_value_d    = out_value_q;
    out_bucket_d   = out_bucket_q;
    head_d         = head_q;
    head_sel_ram_d = head_sel_ram_q;
    if (accept_s) begin
      out_valid_d  = 1'b1;
      out_cmd_d    = bus.in_cmd_i;
      out_key_d    = bus.in_key_i;
      out_value_d  = bus.in_value_i;
      out_bucket_d = bus.in_bucket_i;
      if (wr_live_s && (bus.wr_bucket_i == bus.in_bucket_i)) begin
        head_d         = wr_entry_s;
        head_sel_ram_d = 1'b0;
      end else begin
        head_sel_ram_d = 1'b1;
      end
    end else if (stall_s) begin
      if (wr_live_s && (bus.wr_bucket_i == out_bucket_q)) begin
        head_d         = wr_entry_s;
        head_sel_ram_d = 1'b0;
      end else begin
        head_sel_ram_d = head_sel_ram_q;
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      clr_addr_q     <= {BUCKET_WIDTH{1'b0}};
      done_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_cmd_q      <= 2'b00;
      out_key_q      <= {KEY_WIDTH{1'b0}};
      out_value_q    <= {VALUE_WIDTH{1'b0}};
      out_bucket_q   <= {BUCKET_WIDTH{1'b0}};
      head_q         <= ZERO_ENTRY;
      head_sel_ram_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_addr_q     <= clr_addr_d;
      done_q         <= done_d;
      out_valid_q    <= out_valid_d;
      out_cmd_q      <= out_cmd_d;
      out_key_q      <= out_key_d;
      out_value_q    <= out_value_d;
      out_bucket_q   <= out_bucket_d;
      head_q         <= head_d;
      head_sel_ram_q <= head_sel_ram_d;
    end
  end

  // Head fields come straight from the RAM read register unless a bypass replaced them
  always_comb begin
    if (head_sel_ram_q) begin
      head_out_s = ram_q;
    end else begin
      head_out_s = head_q;
    end
  end

  assign bus.in_ready_o         = in_ready_s;
  assign bus.out_valid_o        = out_valid_q;
  assign bus.out_cmd_o          = out_cmd_q;
  assign bus.out_key_o          = out_key_q;
  assign bus.out_value_o        = out_value_q;
  assign bus.out_bucket_o       = out_bucket_q;
  assign bus.out_head_ptr_o     = head_out_s[ENTRY_W-1:1];
  assign bus.out_head_ptr_val_o = head_out_s[0];
  assign bus.clear_ram_done_o   = done_q;

endmodule

// File: tb/tb_head_table.sv
// Directed plus randomized bench for head_table, checked cycle by cycle against a
// table-level reference model (array of bucket heads, expected output record).
module tb_head_table;

  localparam int KW    = 32;
  localparam int VW    = 16;
  localparam int BW    = 8;
  localparam int PW    = 10;
  localparam int DEPTH = 256;

  logic clk;
  logic rst;

  head_table_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .BUCKET_WIDTH(BW), .HEAD_PTR_WIDTH(PW)) bus ();

  head_table #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .BUCKET_WIDTH(BW), .HEAD_PTR_WIDTH(PW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic [PW-1:0] m_ptr   [DEPTH];
  bit            m_val   [DEPTH];
  bit            m_known [DEPTH];
  bit            e_valid;
  logic [1:0]    e_cmd;
  logic [KW-1:0] e_key;
  logic [VW-1:0] e_value;
  logic [BW-1:0] e_bucket;
  logic [PW-1:0] e_ptr;
  bit            e_hval;
  bit            e_hknown;
  bit            c_active;
  int            c_idx;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(bus.out_valid_o), 64'(e_valid));
    chk("out_cmd", 64'(bus.out_cmd_o), 64'(e_cmd));
    chk("out_key", 64'(bus.out_key_o), 64'(e_key));
    chk("out_value", 64'(bus.out_value_o), 64'(e_value));
    chk("out_bucket", 64'(bus.out_bucket_o), 64'(e_bucket));
    chk("clear_done", 64'(bus.clear_ram_done_o), 64'(c_active && (c_idx == DEPTH - 1)));
    if (e_hknown) begin
      chk("head_ptr", 64'(bus.out_head_ptr_o), 64'(e_ptr));
      chk("head_val", 64'(bus.out_head_ptr_val_o), 64'(e_hval));
    end
  endtask

  task automatic set_idle();
    bus.in_valid_i        = 1'b0;
    bus.in_cmd_i          = 2'd0;
    bus.in_key_i          = 32'd0;
    bus.in_value_i        = 16'd0;
    bus.in_bucket_i       = 8'd0;
    bus.out_ready_i       = 1'b1;
    bus.wr_en_i           = 1'b0;
    bus.wr_bucket_i       = 8'd0;
    bus.wr_head_ptr_i     = 10'd0;
    bus.wr_head_ptr_val_i = 1'b0;
    bus.clear_ram_run_i   = 1'b0;
  endtask

  // One clock: check ready, apply the edge to the model, check the outputs
  task automatic tick();
    logic rdy, acc, wl, run, ordy, wen, wval;
    logic [1:0] cmd;
    logic [KW-1:0] key;
    logic [VW-1:0] val;
    logic [BW-1:0] ib, wb;
    logic [PW-1:0] wptr;
    #1;
    rdy = !c_active && (!e_valid || bus.out_ready_i);
    chk("in_ready", 64'(bus.in_ready_o), 64'(rdy));
    acc  = bus.in_valid_i && rdy;
    run  = bus.clear_ram_run_i;
    ordy = bus.out_ready_i;
    wen  = bus.wr_en_i;
    wb   = bus.wr_bucket_i;
    wptr = bus.wr_head_ptr_i;
    wval = bus.wr_head_ptr_val_i;
    cmd  = bus.in_cmd_i;
    key  = bus.in_key_i;
    val  = bus.in_value_i;
    ib   = bus.in_bucket_i;
    @(posedge clk);
    wl = wen && !c_active;
    if (c_active) begin
      if (run) begin
        c_idx = 0;
      end else begin
        m_ptr[c_idx] = '0;
        m_val[c_idx] = 1'b0;
        m_known[c_idx] = 1'b1;
        if (c_idx == DEPTH - 1) c_active = 1'b0;
        else c_idx++;
      end
    end else if (run) begin
      c_active = 1'b1;
      c_idx = 0;
    end
    if (wl) begin
      m_ptr[wb] = wptr;
      m_val[wb] = wval;
      m_known[wb] = 1'b1;
    end
    if (acc) begin
      e_valid = 1'b1;
      e_cmd = cmd; e_key = key; e_value = val; e_bucket = ib;
      e_ptr = m_ptr[ib]; e_hval = m_val[ib]; e_hknown = m_known[ib];
    end else if (e_valid && !ordy) begin
      if (wl && (wb == e_bucket)) begin
        e_ptr = wptr; e_hval = wval; e_hknown = 1'b1;
      end
    end else begin
      e_valid = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    e_valid = 1'b0; e_cmd = '0; e_key = '0; e_value = '0; e_bucket = '0;
    e_ptr = '0; e_hval = 1'b0; e_hknown = 1'b1;
    c_active = 1'b0; c_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    rst = 1'b0;
  endtask

  task automatic lookup(input logic [BW-1:0] b, input logic [KW-1:0] k);
    bus.in_valid_i  = 1'b1;
    bus.in_bucket_i = b;
    bus.in_key_i    = k;
    bus.in_value_i  = k[15:0] ^ 16'hA5A5;
    bus.in_cmd_i    = k[1:0];
    tick();
    bus.in_valid_i  = 1'b0;
  endtask

  // Pulse clear and count busy cycles / done pulses over the sweep
  task automatic run_clear(input string tag);
    int busy, dcount, dcyc;
    busy = 0; dcount = 0; dcyc = 0;
    bus.clear_ram_run_i = 1'b1;
    tick();
    bus.clear_ram_run_i = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      if (!bus.in_ready_o) busy++;
      if (bus.clear_ram_done_o) begin dcount++; dcyc = i; end
      tick();
    end
    if (bus.clear_ram_done_o) dcount++;
    chk({tag, "_busy"}, 64'(busy), 64'd256);
    chk({tag, "_done_cnt"}, 64'(dcount), 64'd1);
    chk({tag, "_done_cycle"}, 64'(dcyc), 64'd256);
  endtask

  initial begin
    logic [KW-1:0] skey;
    int b2b;
    rst = 1'b1;
    set_idle();
    do_reset();
    tick();

    run_clear("clear1");
    lookup(8'h5A, 32'h1111_0001);
    chk("lookup_5a_val", 64'(bus.out_head_ptr_val_o), 64'd0);

    bus.wr_en_i = 1'b1; bus.wr_bucket_i = 8'h10; bus.wr_head_ptr_i = 10'h3FF; bus.wr_head_ptr_val_i = 1'b1;
    tick();
    bus.wr_en_i = 1'b0;
    lookup(8'h10, 32'h2222_0010);
    chk("w10_valid", 64'(bus.out_valid_o), 64'd1);
    chk("w10_ptr", 64'(bus.out_head_ptr_o), 64'h3FF);
    chk("w10_val", 64'(bus.out_head_ptr_val_o), 64'd1);

    bus.wr_en_i = 1'b1; bus.wr_bucket_i = 8'h22; bus.wr_head_ptr_i = 10'h005; bus.wr_head_ptr_val_i = 1'b1;
    lookup(8'h22, 32'h3333_0022);
    bus.wr_en_i = 1'b0;
    chk("bypass22_ptr", 64'(bus.out_head_ptr_o), 64'h005);
    chk("bypass22_val", 64'(bus.out_head_ptr_val_o), 64'd1);

    bus.wr_en_i = 1'b1; bus.wr_bucket_i = 8'h33; bus.wr_head_ptr_i = 10'h123; bus.wr_head_ptr_val_i = 1'b1;
    tick();
    bus.wr_en_i = 1'b0;
    skey = 32'hCAFE_0033;
    lookup(8'h33, skey);
    bus.out_ready_i = 1'b0;
    chk("stall_ptr_before", 64'(bus.out_head_ptr_o), 64'h123);
    for (int s = 0; s < 5; s++) begin
      if (s == 1) begin
        bus.wr_en_i = 1'b1; bus.wr_bucket_i = 8'h33; bus.wr_head_ptr_i = 10'h000; bus.wr_head_ptr_val_i = 1'b0;
      end else if (s == 3) begin
        bus.wr_en_i = 1'b1; bus.wr_bucket_i = 8'h34; bus.wr_head_ptr_i = 10'h2AA; bus.wr_head_ptr_val_i = 1'b1;
      end else begin
        bus.wr_en_i = 1'b0;
      end
      tick();
    end
    bus.wr_en_i = 1'b0;
    chk("stall_val_dropped", 64'(bus.out_head_ptr_val_o), 64'd0);
    chk("stall_key_stable", 64'(bus.out_key_o), 64'(skey));
    chk("stall_valid_held", 64'(bus.out_valid_o), 64'd1);
    bus.out_ready_i = 1'b1;
    tick();

    b2b = 0;
    for (int b = 1; b <= 16; b++) begin
      lookup(8'(b), 32'(b * 7919));
      bus.in_valid_i = 1'b1;
      if (bus.out_valid_o && (bus.out_bucket_o == 8'(b))) b2b++;
    end
    bus.in_valid_i = 1'b0;
    tick();
    chk("b2b_in_order", 64'(b2b), 64'd16);

    for (int i = 0; i < 700; i++) begin
      bus.in_valid_i        = 1'($urandom_range(0, 1));
      bus.in_cmd_i          = 2'($urandom_range(0, 3));
      bus.in_key_i          = $urandom();
      bus.in_value_i        = 16'($urandom());
      bus.in_bucket_i       = 8'($urandom_range(0, 7));
      bus.out_ready_i       = ($urandom_range(0, 3) != 0);
      bus.wr_en_i           = 1'($urandom_range(0, 1));
      bus.wr_bucket_i       = 8'($urandom_range(0, 7));
      bus.wr_head_ptr_i     = 10'($urandom());
      bus.wr_head_ptr_val_i = 1'($urandom_range(0, 1));
      bus.clear_ram_run_i   = (i == 300);
      tick();
    end
    set_idle();
    tick();

    bus.clear_ram_run_i = 1'b1;
    tick();
    bus.clear_ram_run_i = 1'b0;
    for (int k = 0; k < 300 && c_idx != 100; k++) tick();
    chk("midclr_busy", 64'(bus.in_ready_o), 64'd0);
    do_reset();
    tick();
    run_clear("clear2");
    lookup(8'h5A, 32'h4444_005A);
    chk("post_clear_5a_val", 64'(bus.out_head_ptr_val_o), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
